grid_issue_sched: RTL and testbench

- Issue scheduler in front of the gridding accumulator memory. The accumulator performs read-modify-write: it reads two BRAM rows at issue and writes them back 4 cycles later.
- This block accepts a valid/ready stream of 15-sample complex accumulate requests and forwards them one per cycle.
- It stalls any request whose row footprint overlaps a write still in flight. This prevents read-after-write loss when neighbouring grid points arrive back-to-back.
- It also provides a flush/drain sequence so upstream can tell when all accumulations have landed.

---
 rtl/grid_issue_sched_if.sv | 29 ++
 rtl/grid_issue_sched.sv | 135 +++++++++++++
 tb/tb_grid_issue_sched.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_issue_sched_if.sv
// Request stream into the issue scheduler and the issue bus toward the
// gridding accumulator. The scheduler uses the slave view; upstream and
// downstream logic use the master view.
interface grid_issue_sched_if #(
    parameter int DATA_PATH_WIDTH = 960,
    parameter int ADDR_WIDTH      = 14
);
    // Upstream request stream (valid/ready)
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_PATH_WIDTH-1:0] in_data;
    logic [ADDR_WIDTH-1:0]      in_addr;
    logic                       in_we;

    // Issue bus to the accumulator read-modify-write port
    logic [DATA_PATH_WIDTH-1:0] acc_din;
    logic [ADDR_WIDTH-1:0]      acc_addr;
    logic                       acc_we;

    modport slave (
        input  in_valid, in_data, in_addr, in_we,
        output in_ready, acc_din, acc_addr, acc_we
    );

    modport master (
        output in_valid, in_data, in_addr, in_we,
        input  in_ready, acc_din, acc_addr, acc_we
    );
endinterface

// File: rtl/grid_issue_sched.sv
// Issue scheduler in front of the gridding accumulator. Forwards one request
// per cycle, holds any request whose two-row footprint overlaps a write still
// inside the accumulator's read-modify-write window, and offers a flush/drain
// handshake so upstream knows when every accumulation has landed.
module grid_issue_sched #(
    parameter int COMPLEX               = 2,
    parameter int PRECISION             = 32,
    parameter int PARALLELISM           = 15,
    parameter int BRAM_PARALLELISM_BITS = 4,
    parameter int BRAM_DEPTH_BITS       = 10,
    parameter int HAZARD_WINDOW         = 4,
    parameter int DATA_PATH_WIDTH       = PARALLELISM * PRECISION * COMPLEX,
    parameter int ADDR_WIDTH            = BRAM_DEPTH_BITS + BRAM_PARALLELISM_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    grid_issue_sched_if.slave    bus,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 busy,
    output logic [31:0]          stall_cnt
);

    localparam int                 ROW_W   = BRAM_DEPTH_BITS;
    localparam logic [ROW_W-1:0]   ROW_ONE = ROW_W'(1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [HAZARD_WINDOW-1:0]   hist_v_q;
    logic [ROW_W-1:0]           hist_row_q [HAZARD_WINDOW];
    logic                       acc_we_q;
    logic [ADDR_WIDTH-1:0]      acc_addr_q;
    logic [DATA_PATH_WIDTH-1:0] acc_din_q;
    logic [31:0]                stall_cnt_q;

    logic [ROW_W-1:0]           row_in;
    logic                       hazard;
    logic                       accepting;
    logic                       accept;

    assign row_in = bus.in_addr[ADDR_WIDTH-1:BRAM_PARALLELISM_BITS];

    // Hazard: incoming row within +/-1 (mod depth) of any in-flight write row
    always_comb begin
        // NOTE: default assigned first so no path leaves hazard unassigned (no latch).
        hazard = 1'b0;
        for (int i = 0; i < HAZARD_WINDOW; i++) begin
            if (hist_v_q[i] &&
                ((row_in == hist_row_q[i]) ||
                 (row_in == hist_row_q[i] + ROW_ONE) ||
                 (row_in == hist_row_q[i] - ROW_ONE))) begin
                hazard = 1'b1;
            end
        end
    end

    // Ready is combinational; held low during reset so nothing is taken then
    assign bus.in_ready = !rst && accepting && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst) state_q <= ST_ACTIVE;
        else     state_q <= state_d;
    end

    // FSM next state: flush starts a drain, drain ends once nothing is in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (flush) state_d = ST_DRAIN;
            ST_DRAIN:  if ((hist_v_q == '0) && !acc_we_q) state_d = ST_DONE;
            ST_DONE:   state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // FSM outputs
    always_comb begin
        accepting  = (state_q == ST_ACTIVE);
        flush_done = (state_q == ST_DONE);
        busy       = (state_q != ST_ACTIVE) || (hist_v_q != '0) || acc_we_q;
    end

    // Write-history valid bits: shift every cycle, new entry only for accepted writes
    always_ff @(posedge clk) begin
        if (rst) hist_v_q <= '0;
        else     hist_v_q <= {hist_v_q[HAZARD_WINDOW-2:0], accept && bus.in_we};
    end

    // Write-history rows: qualified by the valid bits, so they need no reset
    always_ff @(posedge clk) begin
        // NOTE: data-only storage is left unreset; the valid bits alone make it meaningful.
        hist_row_q[0] <= row_in;
        for (int i = 1; i < HAZARD_WINDOW; i++) begin
            hist_row_q[i] <= hist_row_q[i-1];
        end
    end

    // Issue register: one-cycle latency to the accumulator, hold address/data when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_we_q   <= 1'b0;
            acc_addr_q <= '0;
            acc_din_q  <= '0;
        end else begin
            acc_we_q <= accept && bus.in_we;
            if (accept) begin
                acc_addr_q <= bus.in_addr;
                acc_din_q  <= bus.in_data;
            end
        end
    end

    // Saturating count of cycles where upstream offered but was refused
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (bus.in_valid && !bus.in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.acc_we   = acc_we_q;
    assign bus.acc_addr = acc_addr_q;
    assign bus.acc_din  = acc_din_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_grid_issue_sched.sv
// Self-checking bench for grid_issue_sched: directed scenarios followed by a
// randomized run, all compared against a cycle-level reference model that
// tracks accepted writes by acceptance time rather than by shift register.
module tb_grid_issue_sched;

    localparam int DW    = 960;
    localparam int AW    = 14;
    localparam int HW    = 4;
    localparam int RB    = 4;
    localparam int NROWS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        flush_done;
    logic        busy;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    grid_issue_sched_if #(.DATA_PATH_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    grid_issue_sched dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    // Reference model: list of accepted writes with the cycle they were accepted
    typedef struct {
        int cyc;
        int row;
    } wr_t;

    wr_t             hist[$];
    int              cyc;
    int              mode;        // 0 accepting, 1 draining, 2 drain-complete cycle
    logic            m_acc_we;
    logic [AW-1:0]   m_acc_addr;
    logic [DW-1:0]   m_acc_din;
    longint          m_stall;
    logic            obs_ready;
    logic            obs_done;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A write accepted at cycle c occupies the accumulator during c+1 .. c+HW
    function automatic bit window_busy();
        foreach (hist[i]) if (cyc - hist[i].cyc <= HW) return 1'b1;
        return 1'b0;
    endfunction

    // Footprints {r, r+1} and {h, h+1} overlap iff circular distance <= 1
    function automatic bit model_hazard(input int row);
        int d;
        foreach (hist[i]) begin
            if (cyc - hist[i].cyc <= HW) begin
                d = (row - hist[i].row + NROWS) % NROWS;
                if (d == 0 || d == 1 || d == NROWS - 1) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic drive(input bit v, input int a, input bit we, input bit fl);
        bus.in_valid = v;
        bus.in_addr  = AW'(a);
        bus.in_we    = we;
        bus.in_data  = rand_data();
        flush        = fl;
    endtask

    // One clock cycle: check DUT against model mid-cycle, then advance both
    task automatic tick();
        bit exp_ready;
        bit acc;
        int r;
        @(negedge clk);
        r         = int'(bus.in_addr >> RB);
        exp_ready = !rst && (mode == 0) && !model_hazard(r);
        check("in_ready",   bus.in_ready, exp_ready);
        check("acc_we",     bus.acc_we, m_acc_we);
        check("acc_addr",   bus.acc_addr, m_acc_addr);
        check("acc_din",    bus.acc_din, m_acc_din);
        check("flush_done", flush_done, (mode == 2));
        check("busy",       busy, (mode != 0) || window_busy() || m_acc_we);
        check("stall_cnt",  stall_cnt, m_stall[31:0]);
        obs_ready = bus.in_ready;
        obs_done  = flush_done;
        acc       = exp_ready && bus.in_valid;
        @(posedge clk);
        if (rst) begin
            mode = 0;
            hist.delete();
            m_acc_we   = 1'b0;
            m_acc_addr = '0;
            m_acc_din  = '0;
            m_stall    = 0;
        end else begin
            case (mode)
                0: if (flush) mode = 1;
                1: if (!window_busy() && !m_acc_we) mode = 2;
                default: mode = 0;
            endcase
            if (bus.in_valid && !exp_ready && m_stall != 64'hFFFF_FFFF) m_stall++;
            m_acc_we = acc && bus.in_we;
            if (acc) begin
                m_acc_addr = bus.in_addr;
                m_acc_din  = bus.in_data;
            end
            if (acc && bus.in_we) hist.push_back('{cyc: cyc, row: r});
        end
        cyc++;
        while (hist.size() > 0 && cyc - hist[0].cyc > HW) void'(hist.pop_front());
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int          n;
        logic [31:0] s0;
        bit          any_done;
        int          rows[8];

        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        mode       = 0;
        m_acc_we   = 1'b0;
        m_acc_addr = '0;
        m_acc_din  = '0;
        m_stall    = 0;
        rows       = '{0, 1, 2, 3, 500, 1021, 1022, 1023};

        // Reset held two cycles with a request pending: never ready
        rst = 1'b1;
        drive(1'b1, 16, 1'b1, 1'b0);
        tick();
        check("rst_ready0", obs_ready, 1'b0);
        tick();
        check("rst_ready1", obs_ready, 1'b0);
        rst = 1'b0;
        idle(1);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_busy",  busy, 1'b0);

        // Streaming rows 0,4,8,...: accepted every cycle, no stalls
        s0 = stall_cnt;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i * 64, 1'b1, 1'b0);
            tick();
            check("stream_ready", obs_ready, 1'b1);
        end
        idle(1);
        check("stream_stall", stall_cnt - s0, 32'd0);

        // Same-row repeat: held until HW+1 cycles after the first accept
        idle(6);
        s0 = stall_cnt;
        drive(1'b1, 16, 1'b1, 1'b0);
        tick();
        drive(1'b1, 20, 1'b1, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_ready && n < 20);
        check("raw_wait",  n, 5);
        check("raw_stall", stall_cnt - s0, 32'd4);

        // Wrap-around neighbour: row 1023 then row 0 conflicts
        idle(6);
        drive(1'b1, 14'h3FF0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 14'h0005, 1'b1, 1'b0);
        tick();
        check("wrap_stall", obs_ready, 1'b0);
        idle(6);
        drive(1'b1, 14'h3FF0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 14'h0040, 1'b1, 1'b0);
        tick();
        check("wrap_far", obs_ready, 1'b1);

        // Read-only probes are checked but never tracked
        idle(6);
        drive(1'b1, 32, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32, 1'b1, 1'b0);
        tick();
        check("ro_then_wr", obs_ready, 1'b1);
        s0 = stall_cnt;
        drive(1'b1, 32, 1'b0, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_ready && n < 20);
        check("wr_then_ro_wait",  n, 5);
        check("wr_then_ro_stall", stall_cnt - s0, 32'd4);

        // Flush with the third write; requests refused until drain completes
        idle(6);
        drive(1'b1, 0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 64, 1'b1, 1'b0);
        tick();
        drive(1'b1, 128, 1'b1, 1'b1);
        tick();
        check("flush_accept", obs_ready, 1'b1);
        drive(1'b1, 14'h0200, 1'b1, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
            check("drain_ready", obs_ready, 1'b0);
        end while (!obs_done && n < 20);
        check("flush_lat", n, 6);
        tick();
        check("post_flush_ready", obs_ready, 1'b1);

        // Reset in the middle of a drain: no flush_done afterwards
        idle(6);
        drive(1'b1, 0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_done |= obs_done;
        end
        check("rst_abort_done", any_done, 1'b0);

        // Randomized traffic over a small, hazard-prone set of rows
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0,
                  (rows[$urandom_range(0, 7)] << RB) | int'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
